wbit_univ_shiftreg: RTL and testbench

WBIT_UNIV_SHIFTREG -- requirements
Module: wbit_univ_shiftreg

---
 rtl/shreg_pkg.sv | 30 +++
 rtl/shreg_step.sv | 29 ++
 rtl/wbit_univ_shiftreg.sv | 104 ++++++++++
 tb/tb_wbit_univ_shiftreg.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared mode encodings, FSM states and mode classification for the shift register.
// Rotates exist only when SHREG_ROTATE_EN is defined.
package shreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ASR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ROR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Modes that may be repeated over several cycles by a START request.
    function automatic logic mode_is_multi(input logic [2:0] m);
        logic r;
        r = (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ASR);
`ifdef SHREG_ROTATE_EN
        r = r || (m == MODE_ROL) || (m == MODE_ROR);
`endif
        return r;
    endfunction

endpackage

// File: rtl/shreg_step.sv
// One combinational shift/rotate step; LOAD, HOLD and reserved codes pass the value through.
// Rotate arms are present only when SHREG_ROTATE_EN is defined.
module shreg_step
    import shreg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] cur,
    input  logic [2:0]   mode,
    input  logic         sir,
    input  logic         sil,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        case (mode)
            MODE_SHL: nxt = {cur[W-2:0], sir};
            MODE_SHR: nxt = {sil, cur[W-1:1]};
            MODE_ASR: nxt = {cur[W-1], cur[W-1:1]};
`ifdef SHREG_ROTATE_EN
            MODE_ROL: nxt = {cur[W-2:0], cur[W-1]};
            MODE_ROR: nxt = {cur[0], cur[W-1:1]};
`endif
            default:  nxt = cur;
        endcase
    end

endmodule

// File: rtl/wbit_univ_shiftreg.sv
// W-bit universal shift register with immediate single steps and counted multi-step runs.
// Define SHREG_ROTATE_EN to enable the ROL/ROR modes.
module wbit_univ_shiftreg
    import shreg_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RES_N,
    input  logic [2:0]    MODE,
    input  logic [W-1:0]  IN_A,
    input  logic          SIR,
    input  logic          SIL,
    input  logic          START,
    input  logic [AW-1:0] AMT,
    output logic [W-1:0]  OUT,
    output logic          SOL,
    output logic          SOR,
    output logic          BUSY,
    output logic          DONE
);

    localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [2:0]    mode_q, mode_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  out_q, out_d;
    logic [2:0]    step_mode;
    logic [W-1:0]  step_nxt;

    // One stepper serves both paths; RUN uses the latched mode.
    assign step_mode = (state_q == RUN) ? mode_q : MODE;

    shreg_step #(.W(W)) u_step (
        .cur  (out_q),
        .mode (step_mode),
        .sir  (SIR),
        .sil  (SIL),
        .nxt  (step_nxt)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (MODE == MODE_LOAD) begin
                        out_d   = IN_A;
                        state_d = FIN;
                    end else if (mode_is_multi(MODE) && (AMT != '0)) begin
                        mode_d  = MODE;
                        cnt_d   = AMT;
                        state_d = RUN;
                    end else begin
                        state_d = FIN;
                    end
                end else if (MODE == MODE_LOAD) begin
                    out_d = IN_A;
                end else begin
                    out_d = step_nxt;
                end
            end
            RUN: begin
                out_d = step_nxt;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q <= IDLE;
            mode_q  <= MODE_HOLD;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign OUT  = out_q;
    assign SOL  = out_q[W-1];
    assign SOR  = out_q[0];
    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == FIN);

endmodule

// File: tb/tb_wbit_univ_shiftreg.sv
// Directed bench for wbit_univ_shiftreg (W=8, AW=4); expectations follow SHREG_ROTATE_EN.
module tb_wbit_univ_shiftreg;
    import shreg_pkg::*;

    logic       CLK = 1'b0;
    logic       RES_N;
    logic [2:0] MODE;
    logic [7:0] IN_A;
    logic       SIR, SIL, START;
    logic [3:0] AMT;
    logic [7:0] OUT;
    logic       SOL, SOR, BUSY, DONE;

    int checks = 0;
    int errors = 0;

    wbit_univ_shiftreg #(.W(8), .AW(4)) dut (
        .CLK(CLK), .RES_N(RES_N), .MODE(MODE), .IN_A(IN_A),
        .SIR(SIR), .SIL(SIL), .START(START), .AMT(AMT),
        .OUT(OUT), .SOL(SOL), .SOR(SOR), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        MODE = MODE_LOAD; IN_A = v; START = 1'b0;
        tick();
        MODE = MODE_HOLD; IN_A = 8'h00;
    endtask

    // Issues START and measures BUSY cycles and the cycle DONE appears (cycle 1 follows the START edge).
    task automatic do_start(input logic [2:0] m, input logic [3:0] a, input bit poke,
                            output int busy_n, output int done_k, output logic [7:0] out_first);
        MODE = m; AMT = a; START = 1'b1;
        tick();
        START = 1'b0; MODE = MODE_HOLD; AMT = 4'd0;
        busy_n = 0; done_k = -1; out_first = OUT;
        for (int k = 1; k <= 40; k++) begin
            if (BUSY) busy_n++;
            if (DONE) begin done_k = k; break; end
            if (poke) begin START = k[0]; MODE = MODE_LOAD; IN_A = 8'h77; AMT = 4'd1; end
            tick();
        end
        START = 1'b0; MODE = MODE_HOLD; IN_A = 8'h00; AMT = 4'd0;
    endtask

    task automatic test_reset();
        RES_N = 1'b0; MODE = MODE_HOLD; IN_A = 8'h00;
        SIR = 1'b0; SIL = 1'b0; START = 1'b0; AMT = 4'd0;
        #1;
        checks++; if (OUT !== 8'h00) begin errors++; $display("FAIL reset_out got %h expected 00", OUT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", DONE); end
        @(negedge CLK);
        RES_N = 1'b1;
    endtask

    task automatic test_immediate();
        load(8'hA5);
        checks++; if (OUT !== 8'hA5) begin errors++; $display("FAIL imm_load got %h expected a5", OUT); end
        MODE = MODE_SHL; SIR = 1'b1;
        tick();
        checks++; if (OUT !== 8'h4B) begin errors++; $display("FAIL imm_shl got %h expected 4b", OUT); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL imm_shl_done got %b expected 0", DONE); end
        MODE = MODE_SHR; SIR = 1'b0; SIL = 1'b1;
        tick();
        checks++; if (OUT !== 8'hA5) begin errors++; $display("FAIL imm_shr got %h expected a5", OUT); end
        MODE = MODE_ASR; SIL = 1'b0;
        tick();
        checks++; if (OUT !== 8'hD2) begin errors++; $display("FAIL imm_asr got %h expected d2", OUT); end
        checks++; if ({SOL, SOR} !== 2'b10) begin errors++; $display("FAIL imm_sol_sor got %b expected 10", {SOL, SOR}); end
        MODE = MODE_RSVD;
        tick();
        checks++; if (OUT !== 8'hD2) begin errors++; $display("FAIL imm_rsvd got %h expected d2", OUT); end
        MODE = MODE_ROL;
        tick();
`ifdef SHREG_ROTATE_EN
        checks++; if (OUT !== 8'hA5) begin errors++; $display("FAIL imm_rol got %h expected a5", OUT); end
`else
        checks++; if (OUT !== 8'hD2) begin errors++; $display("FAIL imm_rol got %h expected d2", OUT); end
`endif
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL imm_busy got %b expected 0", BUSY); end
        MODE = MODE_HOLD;
    endtask

    task automatic test_asr();
        int b, d;
        logic [7:0] f;
        load(8'h90);
        do_start(MODE_ASR, 4'd3, 1'b0, b, d, f);
        checks++; if (f !== 8'h90) begin errors++; $display("FAIL asr_start_edge got %h expected 90", f); end
        checks++; if (b !== 3) begin errors++; $display("FAIL asr_busy got %0d expected 3", b); end
        checks++; if (d !== 4) begin errors++; $display("FAIL asr_done_cycle got %0d expected 4", d); end
        checks++; if (OUT !== 8'hF2) begin errors++; $display("FAIL asr_out got %h expected f2", OUT); end
        tick();
        checks++; if ({BUSY, DONE} !== 2'b00) begin errors++; $display("FAIL asr_idle got %b expected 00", {BUSY, DONE}); end
        checks++; if (OUT !== 8'hF2) begin errors++; $display("FAIL asr_hold got %h expected f2", OUT); end
    endtask

    task automatic test_rotate();
        int b, d;
        logic [7:0] f;
        load(8'h81);
        do_start(MODE_ROL, 4'd8, 1'b0, b, d, f);
        checks++; if (OUT !== 8'h81) begin errors++; $display("FAIL rol8_out got %h expected 81", OUT); end
`ifdef SHREG_ROTATE_EN
        checks++; if (d !== 9) begin errors++; $display("FAIL rol8_done got %0d expected 9", d); end
        checks++; if (b !== 8) begin errors++; $display("FAIL rol8_busy got %0d expected 8", b); end
`else
        checks++; if (d !== 1) begin errors++; $display("FAIL rol8_done got %0d expected 1", d); end
        checks++; if (b !== 0) begin errors++; $display("FAIL rol8_busy got %0d expected 0", b); end
`endif
        tick();
        do_start(MODE_ROR, 4'd3, 1'b0, b, d, f);
`ifdef SHREG_ROTATE_EN
        checks++; if (OUT !== 8'h30) begin errors++; $display("FAIL ror3_out got %h expected 30", OUT); end
        checks++; if (d !== 4) begin errors++; $display("FAIL ror3_done got %0d expected 4", d); end
`else
        checks++; if (OUT !== 8'h81) begin errors++; $display("FAIL ror3_out got %h expected 81", OUT); end
        checks++; if (d !== 1) begin errors++; $display("FAIL ror3_done got %0d expected 1", d); end
`endif
        tick();
    endtask

    task automatic test_shr_long();
        int b, d;
        logic [7:0] f;
        load(8'hFF);
        SIL = 1'b0;
        do_start(MODE_SHR, 4'd10, 1'b1, b, d, f);
        checks++; if (OUT !== 8'h00) begin errors++; $display("FAIL shr10_out got %h expected 00", OUT); end
        checks++; if (b !== 10) begin errors++; $display("FAIL shr10_busy got %0d expected 10", b); end
        checks++; if (d !== 11) begin errors++; $display("FAIL shr10_done got %0d expected 11", d); end
        tick();
        checks++; if ({OUT, DONE} !== 9'h000) begin errors++; $display("FAIL shr10_after got %h expected 000", {OUT, DONE}); end
        load(8'h00);
        SIR = 1'b1;
        do_start(MODE_SHL, 4'd4, 1'b0, b, d, f);
        checks++; if (OUT !== 8'h0F) begin errors++; $display("FAIL shl4_sir got %h expected 0f", OUT); end
        SIR = 1'b0;
        tick();
    endtask

    task automatic test_zero_and_load();
        int b, d;
        logic [7:0] f;
        load(8'h5A);
        do_start(MODE_SHL, 4'd0, 1'b0, b, d, f);
        checks++; if (d !== 1) begin errors++; $display("FAIL amt0_done got %0d expected 1", d); end
        checks++; if (OUT !== 8'h5A) begin errors++; $display("FAIL amt0_out got %h expected 5a", OUT); end
        tick();
        do_start(MODE_RSVD, 4'd5, 1'b0, b, d, f);
        checks++; if ({b[3:0], d[3:0]} !== 8'h01) begin errors++; $display("FAIL rsvd_start got busy %0d done %0d expected 0 1", b, d); end
        tick();
        IN_A = 8'h3C;
        do_start(MODE_LOAD, 4'd5, 1'b0, b, d, f);
        checks++; if (f !== 8'h3C) begin errors++; $display("FAIL start_load got %h expected 3c", f); end
        checks++; if (d !== 1) begin errors++; $display("FAIL start_load_done got %0d expected 1", d); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        MODE = MODE_SHL; AMT = 4'd10; START = 1'b1; SIR = 1'b1;
        tick();
        START = 1'b0; MODE = MODE_HOLD;
        tick();
        tick();
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b expected 1", BUSY); end
        #2 RES_N = 1'b0;
        #1;
        checks++; if ({OUT, BUSY, DONE} !== 10'h000) begin errors++; $display("FAIL async_reset got %h expected 000", {OUT, BUSY, DONE}); end
        @(negedge CLK);
        RES_N = 1'b1; SIR = 1'b0;
        MODE = MODE_LOAD; IN_A = 8'h11;
        tick();
        checks++; if ({OUT, BUSY, DONE} !== {8'h11, 2'b00}) begin errors++; $display("FAIL post_reset got %h expected 044", {OUT, BUSY, DONE}); end
        MODE = MODE_HOLD;
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_asr();
        test_rotate();
        test_shr_long();
        test_zero_and_load();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
